// File: rtl/lc3b_mem_responder_if.sv
// LC-3b memory handshake bundle between one datapath port (master) and its memory (slave).
interface lc3b_mem_responder_if;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  modport master (
    output mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
    input  mem_resp, mem_rdata
  );

  modport slave (
    input  mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Word-organised LC-3b memory responder with a programmable number of wait states.
// One instance serves one port; requests are captured in IDLE and always run to completion.
module lc3b_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  lc3b_mem_responder_if.slave  mem
);

  localparam int unsigned Words   = 1 << DEPTH_LOG2;
  localparam logic [3:0]  LatInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [15:0]             wdata_q;
  logic [1:0]              be_q;
  logic                    rd_q, wr_q;
  logic                    resp_q, resp_d;
  logic [15:0]             rdata_q, rdata_d;
  logic [15:0]             mem_q [Words];

  logic                    req;
  logic                    capture;
  logic                    load_rdata;
  logic [DEPTH_LOG2-1:0]   addr_idx;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic                    commit;
  logic                    unused_addr;

  // Upper address bits alias and bit 0 is a byte select that a word memory ignores.
  assign addr_idx    = mem.mem_address[DEPTH_LOG2:1];
  assign unused_addr = ^mem.mem_address;
  assign req         = mem.mem_read | mem.mem_write;
  assign capture     = (state_q == StIdle) && req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req) state_d = (LATENCY == 0) ? StResp : StWait;
      StWait: if (cnt_q == 4'd0) state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero latency RESP is entered on the capture edge, so the live address is used.
  always_comb begin
    cnt_d      = cnt_q;
    resp_d     = (state_d == StResp);
    rdata_d    = rdata_q;
    rd_idx     = (state_q == StIdle) ? addr_idx : idx_q;
    load_rdata = (state_d == StResp) && (state_q != StResp) &&
                 ((state_q == StIdle) ? mem.mem_read : rd_q);
    commit     = (state_q == StResp) && wr_q;
    if (capture) begin
      cnt_d = LatInit;
    end else if (state_q == StWait && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (load_rdata) begin
      rdata_d = mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 16'h0000;
      be_q    <= 2'b00;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      if (capture) begin
        idx_q   <= addr_idx;
        wdata_q <= mem.mem_wdata;
        be_q    <= mem.mem_byte_enable;
        rd_q    <= mem.mem_read;
        wr_q    <= mem.mem_write;
      end
    end
  end

  // Array is deliberately not reset; reset forces IDLE so a pending write never commits.
  always_ff @(posedge clk) begin
    if (commit) begin
      if (be_q[0]) mem_q[idx_q][7:0]  <= wdata_q[7:0];
      if (be_q[1]) mem_q[idx_q][15:8] <= wdata_q[15:8];
    end
  end

  assign mem.mem_resp  = resp_q;
  assign mem.mem_rdata = rdata_q;

endmodule
